echo_indication_packer: RTL

Downstream consumer of the echo engine's indication methods. Accepts `heard` (one 32-bit value) and `heard2` (two 16-bit values) method calls, queues them in a small tagged FIFO, and serializes each call into a framed stream of 32-bit words on a single `pipe$enq` method toward the host transport. A header word carries the method ID and word count. A running message counter is exported for status.

---
 rtl/echo_indication_packer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/echo_indication_packer.sv
// echo_indication_packer
//   Queues `heard` / `heard2` indication calls in a small tagged FIFO and
//   serializes each call as a framed stream of 32-bit words on `pipe_enq`.
//   Frame = header {methodId, wordCount}, then the payload words.
//   Optional feature macro: ECHO_PACK_CHECKSUM_EN appends an XOR trailer word
//   (CHK state) to every frame and counts it in wordCount.
module echo_indication_packer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  input  logic        indication_heard2__ENA,
  input  logic [15:0] indication_heard2_a,
  input  logic [15:0] indication_heard2_b,
  output logic        indication_heard2__RDY,
  output logic        pipe_enq__ENA,
  output logic [31:0] pipe_enq_v,
  input  logic        pipe_enq__RDY,
  output logic [15:0] msgCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef ECHO_PACK_CHECKSUM_EN
  localparam logic [15:0] WC_HEARD  = 16'd3;
  localparam logic [15:0] WC_HEARD2 = 16'd4;
`else
  localparam logic [15:0] WC_HEARD  = 16'd2;
  localparam logic [15:0] WC_HEARD2 = 16'd3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    P0,
    P1
`ifdef ECHO_PACK_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  // FIFO storage: bit 32 is the tag (0 = heard, 1 = heard2)
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output side: the entry currently being framed
  state_t        state_q, state_d;
  logic          tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   msg_q, msg_d;

  logic          space_ok;
  logic          heard_acc;
  logic          heard2_acc;
  logic [1:0]    num_wr;
  logic          pop;
  logic          frame_end;
  logic          fifo_nonempty;
  logic [31:0]   hdr_word;
  logic [31:0]   p0_word;
  logic [31:0]   p1_word;
  logic [31:0]   out_word;

  // Accept side: both methods are ready only when two entries are free,
  // so a same-cycle pair of calls always fits; uses registered occupancy only
  always_comb begin
    space_ok   = (count_q <= CW'(DEPTH - 2));
    heard_acc  = indication_heard__ENA  & space_ok;
    heard2_acc = indication_heard2__ENA & space_ok;
    num_wr     = {1'b0, heard_acc} + {1'b0, heard2_acc};
  end

  assign indication_heard__RDY  = space_ok;
  assign indication_heard2__RDY = space_ok;
  assign fifo_nonempty          = (count_q != '0);

  // FIFO write path: heard lands first, heard2 goes in the next slot if both fire
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + AW'(num_wr);
    if (heard_acc) begin
      mem_d[wptr_q] = {1'b0, indication_heard_v};
    end
    if (heard2_acc) begin
      if (heard_acc) begin
        mem_d[wptr_q + AW'(1)] = {1'b1, indication_heard2_a, indication_heard2_b};
      end else begin
        mem_d[wptr_q] = {1'b1, indication_heard2_a, indication_heard2_b};
      end
    end
  end

  // Frame words derived from the held entry; the trailer is the XOR of them
  always_comb begin
    hdr_word = tag_q ? {16'd1, WC_HEARD2} : {16'd0, WC_HEARD};
    p0_word  = tag_q ? {16'd0, data_q[31:16]} : data_q;
    p1_word  = {16'd0, data_q[15:0]};
  end

  // Output FSM: next state, word mux, pop request and end-of-frame detection
  always_comb begin
    state_d   = state_q;
    out_word  = 32'd0;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        out_word = hdr_word;
        if (pipe_enq__RDY) begin
          state_d = P0;
        end
      end
      P0: begin
        out_word = p0_word;
        if (pipe_enq__RDY) begin
          if (tag_q) begin
            state_d = P1;
          end else begin
`ifdef ECHO_PACK_CHECKSUM_EN
            state_d = CHK;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
      P1: begin
        out_word = p1_word;
        if (pipe_enq__RDY) begin
`ifdef ECHO_PACK_CHECKSUM_EN
          state_d = CHK;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef ECHO_PACK_CHECKSUM_EN
      CHK: begin
        out_word = hdr_word ^ p0_word ^ (tag_q ? p1_word : 32'd0);
        if (pipe_enq__RDY) begin
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Back-to-back frames: pop the next entry on the last handshake, no bubble
    if (frame_end) begin
      if (fifo_nonempty) begin
        pop     = 1'b1;
        state_d = HDR;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Read pointer, occupancy (net of push/pop), held entry and message counter
  always_comb begin
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(num_wr) - CW'(pop);
    tag_d   = tag_q;
    data_d  = data_q;
    msg_d   = msg_q;
    if (pop) begin
      tag_d  = mem_q[rptr_q][32];
      data_d = mem_q[rptr_q][31:0];
    end
    if (frame_end) begin
      msg_d = msg_q + 16'd1;
    end
  end

  assign pipe_enq__ENA = (state_q != IDLE);
  assign pipe_enq_v    = out_word;
  assign msgCount      = msg_q;

  // State registers; reset drops any partial frame and all queued entries
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      tag_q   <= 1'b0;
      data_q  <= '0;
      msg_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      msg_q   <= msg_d;
    end
  end

endmodule
